// File: rtl/cms_pix28_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// cms_pix28_cmd_sequencer
//
// Command front-end for one CMS PIX28 firmware IP slot. Command words arriving
// from the AXI register bridge are laid out as {device_id[3:0], op_code[3:0],
// body[23:0]}. The block answers only to FIRMWARE_ID. It does four things:
//   - holds the two static configuration registers,
//   - forwards array-config writes and read requests to the array engine,
//   - launches tests and tracks their completion,
//   - maintains the 32-bit firmware status register.
// Every strobe and register update appears on the cycle after the command is
// accepted.
//
// Optional feature: define CMS_PIX28_CMD_TIMEOUT_EN to enable an array-read
// watchdog. When it fires, the block returns a rd_data body of 24'hDEAD00 and
// sets status[30].
//
// Ports:
//   fw_axi_clk, fw_rst_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_data/cmd_ready  command word handshake
//   cfg_static_0/1                latched static configuration bodies
//   arr_wr_valid/arr_sel/arr_wr_data       array-config write strobe
//   arr_rd_req/arr_rd_sub                  array read request
//   arr_rd_valid/arr_rd_data               array read return
//   rd_valid/rd_data              read response {id, op, 24-bit data}
//   exec_start/exec_cfg           test launch pulse and latched W_EXECUTE body
//   test_done                     one-hot per-test done pulses
//   fw_soft_rst                   registered soft reset to the IP (active high)
//   status                        firmware status register
// ----------------------------------------------------------------------------
module cms_pix28_cmd_sequencer #(
  parameter logic [3:0]  FIRMWARE_ID     = 4'h1,
  parameter logic [3:0]  TESTS_SUPPORTED = 4'b0011,
  parameter int unsigned TNUM_LSB        = 14,
  parameter int unsigned RST_CYCLES      = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
  input  logic        fw_axi_clk,
  input  logic        fw_rst_n,
  input  logic        cmd_valid,
  input  logic [31:0] cmd_data,
  output logic        cmd_ready,
  output logic [23:0] cfg_static_0,
  output logic [23:0] cfg_static_1,
  output logic        arr_wr_valid,
  output logic [1:0]  arr_sel,
  output logic [23:0] arr_wr_data,
  output logic        arr_rd_req,
  output logic        arr_rd_sub,
  input  logic        arr_rd_valid,
  input  logic [23:0] arr_rd_data,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        exec_start,
  output logic [23:0] exec_cfg,
  input  logic [3:0]  test_done,
  output logic        fw_soft_rst,
  output logic [31:0] status
);

  typedef enum logic [1:0] {S_IDLE, S_RST_HOLD, S_RD_WAIT, S_EXEC} state_e;

  localparam logic [3:0] OP_NOOP    = 4'h0;
  localparam logic [3:0] OP_RST_FW  = 4'h1;
  localparam logic [3:0] OP_W_CFG0  = 4'h2;
  localparam logic [3:0] OP_R_CFG0  = 4'h3;
  localparam logic [3:0] OP_W_CFG1  = 4'h4;
  localparam logic [3:0] OP_R_CFG1  = 4'h5;
  localparam logic [3:0] OP_W_ARR0  = 4'h6;
  localparam logic [3:0] OP_R_ARR0  = 4'h7;
  localparam logic [3:0] OP_W_ARR1  = 4'h8;
  localparam logic [3:0] OP_R_ARR1  = 4'h9;
  localparam logic [3:0] OP_W_ARR2  = 4'hA;
  localparam logic [3:0] OP_R_ARR2  = 4'hB;
  localparam logic [3:0] OP_R_DAT0  = 4'hC;
  localparam logic [3:0] OP_R_DAT1  = 4'hD;
  localparam logic [3:0] OP_ST_CLR  = 4'hE;
  localparam logic [3:0] OP_EXECUTE = 4'hF;

  // Bits 0..17 plus the error flag are live. Bit 30 is live only when the
  // read watchdog is built in.
`ifdef CMS_PIX28_CMD_TIMEOUT_EN
  localparam logic [31:0] STATUS_MASK = 32'hC003_FFFF;
  localparam int unsigned TMO_W       = $clog2(TIMEOUT_CYCLES + 1);
`else
  localparam logic [31:0] STATUS_MASK = 32'h8003_FFFF;
`endif

  // Command word fields
  logic [3:0]  cmd_id;
  logic [3:0]  cmd_op;
  logic [23:0] cmd_body;
  logic [3:0]  cmd_tnum;
  assign cmd_id   = cmd_data[31:28];
  assign cmd_op   = cmd_data[27:24];
  assign cmd_body = cmd_data[23:0];
  assign cmd_tnum = cmd_body[TNUM_LSB+3 -: 4];

  // Registered state and outputs
  state_e      state_q, state_d;
  state_e      ret_state_q, ret_state_d;   // state to resume after RD_WAIT
  logic [7:0]  rst_cnt_q, rst_cnt_d;
  logic [3:0]  tnum_q, tnum_d;
  logic [7:0]  rd_hdr_q, rd_hdr_d;         // {id, op} of the pending array read
  logic        cmd_ready_q, cmd_ready_d;
  logic [23:0] cfg_static_0_q, cfg_static_0_d;
  logic [23:0] cfg_static_1_q, cfg_static_1_d;
  logic        arr_wr_valid_q, arr_wr_valid_d;
  logic [1:0]  arr_sel_q, arr_sel_d;
  logic [23:0] arr_wr_data_q, arr_wr_data_d;
  logic        arr_rd_req_q, arr_rd_req_d;
  logic        arr_rd_sub_q, arr_rd_sub_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        exec_start_q, exec_start_d;
  logic [23:0] exec_cfg_q, exec_cfg_d;
  logic        fw_soft_rst_q, fw_soft_rst_d;
  logic [31:0] status_q, status_d;
`ifdef CMS_PIX28_CMD_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  logic        accept;
  logic        tnum_ok;
  logic        exec_active;
  logic [3:0]  done_hit;
  logic        exec_done;
  logic        status_clr;
  logic [31:0] status_set;

  // Foreign-device words still complete the handshake; they just do nothing.
  assign accept  = cmd_valid & cmd_ready_q & (cmd_id == FIRMWARE_ID);
  assign tnum_ok = (cmd_tnum != 4'd0) && ((cmd_tnum & (cmd_tnum - 4'd1)) == 4'd0)
                   && ((cmd_tnum & TESTS_SUPPORTED) != 4'd0);

  // A test stays tracked while an array read issued from EXEC is in flight,
  // so its done pulse cannot be lost.
  assign exec_active = (state_q == S_EXEC) ||
                       ((state_q == S_RD_WAIT) && (ret_state_q == S_EXEC));
  assign done_hit    = test_done & tnum_q;
  assign exec_done   = exec_active && (done_hit != 4'd0);

  // NOTE: every signal is given its default at the top of this block, so
  // paths that do not assign it hold the value rather than inferring a latch.
  always_comb begin
    state_d        = state_q;
    ret_state_d    = ret_state_q;
    rst_cnt_d      = rst_cnt_q;
    tnum_d         = tnum_q;
    rd_hdr_d       = rd_hdr_q;
    cfg_static_0_d = cfg_static_0_q;
    cfg_static_1_d = cfg_static_1_q;
    arr_wr_valid_d = 1'b0;
    arr_sel_d      = arr_sel_q;
    arr_wr_data_d  = arr_wr_data_q;
    arr_rd_req_d   = 1'b0;
    arr_rd_sub_d   = arr_rd_sub_q;
    rd_valid_d     = 1'b0;
    rd_data_d      = rd_data_q;
    exec_start_d   = 1'b0;
    exec_cfg_d     = exec_cfg_q;
    fw_soft_rst_d  = 1'b0;
    status_clr     = 1'b0;
    status_set     = '0;
`ifdef CMS_PIX28_CMD_TIMEOUT_EN
    tmo_cnt_d      = tmo_cnt_q;
`endif

    // Done bits are ORed in after any clear, so a same-cycle clear loses.
    if (exec_done) begin
      status_set[17:14] = done_hit;
      if (state_q == S_EXEC) state_d = S_IDLE;
      else                   ret_state_d = S_IDLE;
    end

    case (state_q)
      S_RST_HOLD: begin
        if (rst_cnt_q == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          rst_cnt_d     = rst_cnt_q - 8'd1;
          fw_soft_rst_d = 1'b1;
        end
      end

      S_RD_WAIT: begin
        if (arr_rd_valid) begin
          rd_valid_d = 1'b1;
          rd_data_d  = {rd_hdr_q, arr_rd_data};
          status_set = status_set | (32'd1 << (rd_hdr_q[3:0] - 4'd1));
          state_d    = ret_state_d;
        end
`ifdef CMS_PIX28_CMD_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          rd_valid_d     = 1'b1;
          rd_data_d      = {rd_hdr_q, 24'hDEAD00};
          status_set[30] = 1'b1;
          state_d        = ret_state_d;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
`endif
      end

      default: begin  // S_IDLE, S_EXEC
        if (accept) begin
          case (cmd_op)
            OP_NOOP: ;

            OP_RST_FW: begin
              // Abort everything, including any test in flight.
              state_d        = S_RST_HOLD;
              rst_cnt_d      = 8'(RST_CYCLES - 1);
              fw_soft_rst_d  = 1'b1;
              cfg_static_0_d = '0;
              cfg_static_1_d = '0;
              exec_cfg_d     = '0;
              tnum_d         = '0;
              status_clr     = 1'b1;
              status_set     = 32'h0000_0001;
            end

            OP_W_CFG0, OP_W_CFG1: begin
              if (cmd_op == OP_W_CFG0) cfg_static_0_d = cmd_body;
              else                     cfg_static_1_d = cmd_body;
              status_set = status_set | (32'd1 << (cmd_op - 4'd1));
            end

            OP_R_CFG0, OP_R_CFG1: begin
              rd_valid_d = 1'b1;
              rd_data_d  = {cmd_data[31:24],
                            (cmd_op == OP_R_CFG0) ? cfg_static_0_q : cfg_static_1_q};
              status_set = status_set | (32'd1 << (cmd_op - 4'd1));
            end

            OP_W_ARR0, OP_W_ARR1, OP_W_ARR2: begin
              arr_wr_valid_d = 1'b1;
              arr_sel_d      = 2'((cmd_op - 4'd6) >> 1);
              arr_wr_data_d  = cmd_body;
              status_set     = status_set | (32'd1 << (cmd_op - 4'd1));
            end

            OP_R_ARR0, OP_R_ARR1, OP_R_ARR2, OP_R_DAT0, OP_R_DAT1: begin
              arr_rd_req_d = 1'b1;
              if (cmd_op >= OP_R_DAT0) begin
                arr_sel_d    = 2'd3;
                arr_rd_sub_d = cmd_op[0];
              end else begin
                arr_sel_d    = 2'((cmd_op - 4'd7) >> 1);
                arr_rd_sub_d = 1'b0;
              end
              rd_hdr_d    = cmd_data[31:24];
              ret_state_d = ((state_q == S_EXEC) && !exec_done) ? S_EXEC : S_IDLE;
              state_d     = S_RD_WAIT;
`ifdef CMS_PIX28_CMD_TIMEOUT_EN
              tmo_cnt_d   = '0;
`endif
            end

            OP_ST_CLR: status_clr = 1'b1;

            OP_EXECUTE: begin
              if ((state_q == S_IDLE) && tnum_ok) begin
                exec_cfg_d     = cmd_body;
                tnum_d         = cmd_tnum;
                exec_start_d   = 1'b1;
                status_set[13] = 1'b1;
                state_d        = S_EXEC;
              end else begin
                status_set[31] = 1'b1;
              end
            end

            default: ;
          endcase
        end
      end
    endcase

    status_d    = ((status_clr ? 32'd0 : status_q) | status_set) & STATUS_MASK;
    cmd_ready_d = (state_d == S_IDLE) || (state_d == S_EXEC);
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge fw_axi_clk or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      state_q        <= S_IDLE;
      ret_state_q    <= S_IDLE;
      rst_cnt_q      <= '0;
      tnum_q         <= '0;
      rd_hdr_q       <= '0;
      cmd_ready_q    <= 1'b1;   // ready straight out of reset
      cfg_static_0_q <= '0;
      cfg_static_1_q <= '0;
      arr_wr_valid_q <= 1'b0;
      arr_sel_q      <= '0;
      arr_wr_data_q  <= '0;
      arr_rd_req_q   <= 1'b0;
      arr_rd_sub_q   <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
      exec_start_q   <= 1'b0;
      exec_cfg_q     <= '0;
      fw_soft_rst_q  <= 1'b0;
      status_q       <= '0;
`ifdef CMS_PIX28_CMD_TIMEOUT_EN
      tmo_cnt_q      <= '0;
`endif
    end else begin
      state_q        <= state_d;
      ret_state_q    <= ret_state_d;
      rst_cnt_q      <= rst_cnt_d;
      tnum_q         <= tnum_d;
      rd_hdr_q       <= rd_hdr_d;
      cmd_ready_q    <= cmd_ready_d;
      cfg_static_0_q <= cfg_static_0_d;
      cfg_static_1_q <= cfg_static_1_d;
      arr_wr_valid_q <= arr_wr_valid_d;
      arr_sel_q      <= arr_sel_d;
      arr_wr_data_q  <= arr_wr_data_d;
      arr_rd_req_q   <= arr_rd_req_d;
      arr_rd_sub_q   <= arr_rd_sub_d;
      rd_valid_q     <= rd_valid_d;
      rd_data_q      <= rd_data_d;
      exec_start_q   <= exec_start_d;
      exec_cfg_q     <= exec_cfg_d;
      fw_soft_rst_q  <= fw_soft_rst_d;
      status_q       <= status_d;
`ifdef CMS_PIX28_CMD_TIMEOUT_EN
      tmo_cnt_q      <= tmo_cnt_d;
`endif
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign cfg_static_0 = cfg_static_0_q;
  assign cfg_static_1 = cfg_static_1_q;
  assign arr_wr_valid = arr_wr_valid_q;
  assign arr_sel      = arr_sel_q;
  assign arr_wr_data  = arr_wr_data_q;
  assign arr_rd_req   = arr_rd_req_q;
  assign arr_rd_sub   = arr_rd_sub_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign exec_start   = exec_start_q;
  assign exec_cfg     = exec_cfg_q;
  assign fw_soft_rst  = fw_soft_rst_q;
  assign status       = status_q;

endmodule

// File: doc/cms_pix28_cmd_sequencer.md
Name: cms_pix28_cmd_sequencer

Overview:
- Command front-end for one CMS PIX28 firmware IP slot (fw_ip1/fw_ip2).
- Accepts 32-bit command words from the AXI register bridge: [31:28] device_id, [27:24] op_code, [23:0] body.
- Decodes the op_code and holds the static configuration registers. Forwards array-config writes and read requests to the array engine.
- Launches and tracks test execution, and maintains the 32-bit firmware status register.

Parameters:
- FIRMWARE_ID, 4'h1, one-hot device_id this slot answers to.
- TESTS_SUPPORTED, 4'b0011, mask of test_number one-hot codes the attached IP implements.
- TNUM_LSB, 14, LSB of the 4-bit test_number field in the W_EXECUTE body (IP2 uses 12).
- RST_CYCLES, 8, width of the fw_soft_rst pulse in clocks (1..255).
- TIMEOUT_CYCLES, 4096, array-read watchdog limit (used only with the optional feature).

Ports:
- fw_axi_clk  in  1  system clock, 100 MHz
- fw_rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command word present
- cmd_data  in  32  command word
- cmd_ready  out  1  sequencer can accept a command
- cfg_static_0  out  24  latched W_CFG_STATIC_0 body
- cfg_static_1  out  24  latched W_CFG_STATIC_1 body
- arr_wr_valid  out  1  one-cycle array-config write strobe
- arr_sel  out  2  array select: 0..2 = cfg_array_0..2, 3 = data array
- arr_wr_data  out  24  array write body
- arr_rd_req  out  1  one-cycle array read request
- arr_rd_sub  out  1  data-array index (0 = data_array_0, 1 = data_array_1)
- arr_rd_valid  in  1  array read data returned
- arr_rd_data  in  24  array read data
- rd_valid  out  1  one-cycle read response strobe
- rd_data  out  32  read response {device_id, op_code, 24-bit data}
- exec_start  out  1  one-cycle test launch pulse
- exec_cfg  out  24  latched W_EXECUTE body
- test_done  in  4  per-test done pulses, one-hot
- fw_soft_rst  out  1  soft reset to the IP, active high
- status  out  32  status register

Behaviour:
- Reset (fw_rst_n low, asynchronous):
  - All outputs 0 except cmd_ready=1.
  - State IDLE.
- Command acceptance:
  - A command is accepted on cmd_valid & cmd_ready.
  - Words with device_id != FIRMWARE_ID are consumed and have no other effect.
  - All responses, strobes and status updates occur the cycle after acceptance.
- States:
  - IDLE: cmd_ready=1.
  - RST_HOLD: cmd_ready=0.
  - RD_WAIT: cmd_ready=0.
  - EXEC: cmd_ready=1.
- Op codes:
  - 0 NOOP: no action.
  - 1 W_RST_FW: fw_soft_rst=1 for RST_CYCLES cycles in RST_HOLD. Clears cfg_static_0/1, exec_cfg and status, then sets status[0]. Aborts EXEC. Returns to IDLE.
  - 2/4 W_CFG_STATIC_0/1: latch body; set status[1] or status[3].
  - 3/5 R_CFG_STATIC_0/1: rd_valid pulse with rd_data={cmd[31:24], cfg_static_x}; set status[2] or status[4].
  - 6/8/A W_CFG_ARRAY_0/1/2: arr_wr_valid pulse, arr_sel=0/1/2, arr_wr_data=body; set status[5]/[7]/[9].
  - 7/9/B R_CFG_ARRAY_0/1/2 and C/D R_DATA_ARRAY_0/1:
    - Issue an arr_rd_req pulse (arr_sel=0/1/2, or 3 with arr_rd_sub=0/1), then enter RD_WAIT.
    - On arr_rd_valid: rd_valid pulse, rd_data={id, op, arr_rd_data}; set status[6]/[8]/[10]/[11]/[12]; return to the state held before RD_WAIT.
  - E W_STATUS_FW_CLEAR: status=0.
  - F W_EXECUTE: tnum = body[TNUM_LSB+3:TNUM_LSB].
    - Valid means tnum is one-hot and (tnum & TESTS_SUPPORTED) != 0. Valid and in IDLE: latch exec_cfg, pulse exec_start, set status[13], go to EXEC.
    - Invalid tnum, or W_EXECUTE received while in EXEC: set status[31]; no start.
- EXEC:
  - A test_done pulse whose bit matches the latched tnum sets status[14+k] (k = bit index) and returns to IDLE.
  - Non-matching done bits are ignored.
- Simultaneous events:
  - W_STATUS_FW_CLEAR together with a matching test_done in the same cycle leaves only the done bit set (the set wins over the clear).
  - In RST_HOLD, test_done is ignored.
- Status bits [30:18] always read 0.
- fw_soft_rst is registered, glitch-free, and never asserted by fw_rst_n.

Optional Feature:
- Macro CMS_PIX28_CMD_TIMEOUT_EN.
- Defined: a counter runs in RD_WAIT. If TIMEOUT_CYCLES elapse without arr_rd_valid, the block:
  - pulses rd_valid with rd_data={id, op, 24'hDEAD00},
  - sets status[30] (read timeout),
  - returns to the prior state.
  The counter clears on every entry to RD_WAIT.
- Undefined: RD_WAIT waits indefinitely; status[30] is constant 0.

Test Plan:
- Reset, then cmd 0x12ABCDEF (id 1, W_CFG_STATIC_0) followed by 0x13000000 -> cfg_static_0=0xABCDEF; rd_valid with rd_data=0x13ABCDEF; status=0x00000006.
- cmd 0x22123456 (id 2, foreign device) -> no output change; cmd_ready stays 1; status unchanged.
- cmd 0x1F004000 (tnum=1) -> exec_start pulse, exec_cfg=0x004000, status[13]=1. test_done=4'b0010 -> ignored. test_done=4'b0001 -> status[14]=1, state IDLE.
- cmd 0x1F00C000 (tnum=4'b0011, not one-hot) -> no exec_start; status[31]=1. Then 0x1E000000 -> status=0.
- cmd 0x1D000000 -> arr_rd_req with arr_sel=3, arr_rd_sub=1; cmd_ready=0. arr_rd_valid with 0x00BEEF 5 cycles later -> rd_data=0x1D00BEEF; status[12]=1.
- In EXEC, cmd 0x11000000 -> fw_soft_rst high for exactly 8 cycles, cmd_ready=0 throughout; afterwards status=0x00000001, cfg regs 0, IDLE.
